// File: rtl/dense_seq_ctrl.sv
// Sequencer for a time-multiplexed dense layer: walks inputs per output neuron through one
// shared MAC pipeline, drains it, requests the bias add, then commands the result write.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start_i; counters held at zero
// S_RUN   | one MAC issued per non-stalled cycle for the current neuron
// S_DRAIN | MAC_LAT cycles for the last product to reach the accumulator
// S_BIAS  | bias add requested for the current neuron
// S_WRITE | accumulator written to the result RAM
// S_DONE  | one-cycle end-of-pass pulse
module dense_seq_ctrl #(
    parameter int IN_NUMS  = 1600,
    parameter int OUT_NUMS = 128,
    parameter int MAC_LAT  = 1,
    parameter int FA_W     = (IN_NUMS > 1) ? $clog2(IN_NUMS) : 1,
    parameter int KA_W     = (IN_NUMS * OUT_NUMS > 1) ? $clog2(IN_NUMS * OUT_NUMS) : 1,
    parameter int OA_W     = (OUT_NUMS > 1) ? $clog2(OUT_NUMS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            stall_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            mac_en_o,
    output logic            acc_first_o,
    output logic [FA_W-1:0] feat_addr_o,
    output logic [KA_W-1:0] kern_addr_o,
    output logic            bias_en_o,
    output logic [OA_W-1:0] bias_addr_o,
    output logic            res_we_o,
    output logic [OA_W-1:0] res_addr_o
);

    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [FA_W-1:0] IN_LAST    = FA_W'(IN_NUMS - 1);
    localparam logic [OA_W-1:0] OUT_LAST   = OA_W'(OUT_NUMS - 1);
    localparam logic [DW-1:0]   DRAIN_LOAD = DW'(MAC_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_BIAS  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [FA_W-1:0] r_in_idx;
    logic [OA_W-1:0] r_out_idx;
    logic [KA_W-1:0] r_kern;
    logic [DW-1:0]   r_drain;
    logic            w_issue;
    logic            w_in_last;
    logic            w_out_last;

    assign w_in_last  = (r_in_idx == IN_LAST);
    assign w_out_last = (r_out_idx == OUT_LAST);

    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) w_next = S_RUN;
            end
            S_RUN: begin
                if (!stall_i) begin
                    w_issue = 1'b1;
                    if (w_in_last) w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_drain == '0) w_next = S_BIAS;
            end
            S_BIAS:  w_next = S_WRITE;
            S_WRITE: w_next = w_out_last ? S_DONE : S_RUN;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // The kernel address never steps past the last issue of a neuron; the step into the
    // next neuron's block happens on WRITE so the register never leaves 0..IN*OUT-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_in_idx  <= '0;
            r_out_idx <= '0;
            r_kern    <= '0;
            r_drain   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_in_idx  <= '0;
                    r_out_idx <= '0;
                    r_kern    <= '0;
                    r_drain   <= '0;
                end
                S_RUN: begin
                    if (w_issue) begin
                        if (w_in_last) begin
                            r_drain <= DRAIN_LOAD;
                        end else begin
                            r_in_idx <= r_in_idx + 1'b1;
                            r_kern   <= r_kern + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (r_drain != '0) r_drain <= r_drain - 1'b1;
                end
                S_WRITE: begin
                    if (!w_out_last) begin
                        r_out_idx <= r_out_idx + 1'b1;
                        r_in_idx  <= '0;
                        r_kern    <= r_kern + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = (r_state == S_DONE);
    assign mac_en_o    = w_issue;
    assign acc_first_o = w_issue && (r_in_idx == '0);
    assign feat_addr_o = r_in_idx;
    assign kern_addr_o = r_kern;
    assign bias_en_o   = (r_state == S_BIAS);
    assign bias_addr_o = r_out_idx;
    assign res_we_o    = (r_state == S_WRITE);
    assign res_addr_o  = r_out_idx;

endmodule

// File: tb/tb_dense_seq_ctrl.sv
// Bench for dense_seq_ctrl: directed and randomized passes on a 4x3 (MAC_LAT=2) and a 1x1 instance,
// compared per cycle against an event schedule derived from the layer timing rules.
module tb_dense_seq_ctrl;

    localparam int MAXC = 400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start0, start1, stall;

    logic       busy0, done0, mac0, first0, bias0, we0;
    logic [1:0] feat0, baddr0, raddr0;
    logic [3:0] kern0;
    logic       busy1, done1, mac1, first1, bias1, we1;
    logic [0:0] feat1, kern1, baddr1, raddr1;

    dense_seq_ctrl #(.IN_NUMS(4), .OUT_NUMS(3), .MAC_LAT(2)) u_dut0 (
        .clk(clk), .rst(rst), .start_i(start0), .stall_i(stall),
        .busy_o(busy0), .done_o(done0), .mac_en_o(mac0), .acc_first_o(first0),
        .feat_addr_o(feat0), .kern_addr_o(kern0), .bias_en_o(bias0),
        .bias_addr_o(baddr0), .res_we_o(we0), .res_addr_o(raddr0)
    );

    dense_seq_ctrl #(.IN_NUMS(1), .OUT_NUMS(1), .MAC_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .stall_i(stall),
        .busy_o(busy1), .done_o(done1), .mac_en_o(mac1), .acc_first_o(first1),
        .feat_addr_o(feat1), .kern_addr_o(kern1), .bias_en_o(bias1),
        .bias_addr_o(baddr1), .res_we_o(we1), .res_addr_o(raddr1)
    );

    int n_total = 0;
    int n_bad   = 0;

    bit e_mac[MAXC], e_first[MAXC], e_bias[MAXC], e_we[MAXC];
    int e_feat[MAXC], e_kern[MAXC], e_oidx[MAXC];
    bit st[MAXC], sn[MAXC];

    task automatic check_val(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void clear_stim();
        for (int c = 0; c < MAXC; c++) begin
            st[c] = 1'b0;
            sn[c] = 1'b0;
        end
    endfunction

    // Event schedule: each issue takes the next unstalled cycle; bias follows the last
    // issue after MAC_LAT drain cycles, write one cycle later, next neuron right after.
    function automatic int build_sched(input int nin, input int nout, input int lat);
        int c;
        for (int k = 0; k < MAXC; k++) begin
            e_mac[k] = 0; e_first[k] = 0; e_bias[k] = 0; e_we[k] = 0;
            e_feat[k] = 0; e_kern[k] = 0; e_oidx[k] = 0;
        end
        c = 1;
        for (int o = 0; o < nout; o++) begin
            for (int i = 0; i < nin; i++) begin
                while (st[c]) c++;
                e_mac[c]   = 1;
                e_first[c] = (i == 0);
                e_feat[c]  = i;
                e_kern[c]  = o * nin + i;
                c++;
            end
            e_bias[c + lat - 1 + 1 - 1] = 0;
            e_bias[c + lat]     = 1;
            e_oidx[c + lat]     = o;
            e_we[c + lat + 1]   = 1;
            e_oidx[c + lat + 1] = o;
            c = c + lat + 2;
        end
        return c;
    endfunction

    task automatic get_out(input int dsel, output int ctl, output int feat, output int kern,
                           output int baddr, output int raddr);
        if (dsel == 0) begin
            ctl   = int'({busy0, done0, mac0, first0, bias0, we0});
            feat  = int'(feat0);  kern  = int'(kern0);
            baddr = int'(baddr0); raddr = int'(raddr0);
        end else begin
            ctl   = int'({busy1, done1, mac1, first1, bias1, we1});
            feat  = int'(feat1);  kern  = int'(kern1);
            baddr = int'(baddr1); raddr = int'(raddr1);
        end
    endtask

    task automatic drive_start(input int dsel, input logic v);
        start0 = (dsel == 0) ? v : 1'b0;
        start1 = (dsel == 1) ? v : 1'b0;
    endtask

    task automatic check_all_zero(input int dsel, input string tag);
        int ctl, feat, kern, baddr, raddr;
        get_out(dsel, ctl, feat, kern, baddr, raddr);
        check_val({tag, "_ctl"}, ctl, 0);
        check_val({tag, "_addr"}, feat + kern + baddr + raddr, 0);
    endtask

    task automatic run_pass(input int dsel, input bit hold, input int rst_at,
                            input bit noise, input bit start_in_done);
        int nin, nout, lat, done_c, ctl, feat, kern, baddr, raddr, exp_ctl;
        nin  = (dsel == 0) ? 4 : 1;
        nout = (dsel == 0) ? 3 : 1;
        lat  = (dsel == 0) ? 2 : 1;
        st[0] = 1'b0;
        done_c = build_sched(nin, nout, lat);

        @(posedge clk); #1;
        drive_start(dsel, 1'b1);
        stall = 1'b0;
        @(negedge clk);
        get_out(dsel, ctl, feat, kern, baddr, raddr);
        check_val($sformatf("d%0d_c0_ctl", dsel), ctl, 0);

        for (int c = 1; c <= done_c; c++) begin
            @(posedge clk); #1;
            if (c == rst_at) rst = 1'b1;
            drive_start(dsel, hold | (noise & sn[c]) | (start_in_done && c == done_c));
            stall = st[c];
            @(negedge clk);
            get_out(dsel, ctl, feat, kern, baddr, raddr);
            exp_ctl = {1'b1, (c == done_c), e_mac[c], e_first[c], e_bias[c], e_we[c]};
            check_val($sformatf("d%0d_c%0d_ctl", dsel, c), ctl, exp_ctl);
            if (e_mac[c]) begin
                check_val($sformatf("d%0d_c%0d_feat", dsel, c), feat, e_feat[c]);
                check_val($sformatf("d%0d_c%0d_kern", dsel, c), kern, e_kern[c]);
            end
            if (e_bias[c]) check_val($sformatf("d%0d_c%0d_baddr", dsel, c), baddr, e_oidx[c]);
            if (e_we[c])   check_val($sformatf("d%0d_c%0d_raddr", dsel, c), raddr, e_oidx[c]);
            if (c == rst_at) break;
        end

        if (rst_at > 0) begin
            for (int k = 1; k <= 3; k++) begin
                @(posedge clk); #1;
                rst = 1'b0;
                drive_start(dsel, 1'b0);
                stall = 1'($urandom_range(0, 1));
                @(negedge clk);
                check_all_zero(dsel, $sformatf("d%0d_postrst%0d", dsel, k));
            end
        end else if (!hold) begin
            @(posedge clk); #1;
            drive_start(dsel, 1'b0);
            stall = 1'($urandom_range(0, 1));
            @(negedge clk);
            get_out(dsel, ctl, feat, kern, baddr, raddr);
            check_val($sformatf("d%0d_after_done_ctl", dsel), ctl, 0);
        end
    endtask

    task automatic random_stim(input int stall_pct, input int start_pct);
        clear_stim();
        for (int c = 1; c < 100; c++) begin
            st[c] = ($urandom_range(0, 99) < stall_pct);
            sn[c] = ($urandom_range(0, 99) < start_pct);
        end
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; stall = 1'b0;
        repeat (3) @(posedge clk);
        #1 start0 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        check_all_zero(0, "reset0");
        check_all_zero(1, "reset1");
        @(posedge clk); #1;
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
        @(negedge clk);
        check_all_zero(0, "idle0");

        clear_stim();
        run_pass(0, 0, 0, 0, 0);

        clear_stim();
        st[2] = 1'b1; st[3] = 1'b1;
        run_pass(0, 0, 0, 0, 0);

        clear_stim();
        sn[5] = 1'b1;
        run_pass(0, 0, 0, 1, 1);

        clear_stim();
        run_pass(0, 1, 0, 0, 0);
        run_pass(0, 0, 0, 0, 0);

        clear_stim();
        run_pass(0, 0, 10, 0, 0);
        clear_stim();
        run_pass(0, 0, 0, 0, 0);

        clear_stim();
        run_pass(1, 0, 0, 0, 0);
        random_stim(40, 30);
        run_pass(1, 0, 0, 1, 1);

        for (int p = 0; p < 10; p++) begin
            random_stim(35, 25);
            run_pass(0, 0, 0, 1, (p % 2) == 0);
        end

        random_stim(30, 0);
        run_pass(0, 0, int'($urandom_range(2, 20)), 0, 0);
        clear_stim();
        run_pass(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/dense_seq_ctrl.md
# dense_seq_ctrl

Sequencer for a time-multiplexed dense (fully connected) layer. It drives one shared FloatingMultiplication → FloatingAddition accumulate pipeline instead of one multiplier per weight. For each output neuron it walks all input features, waits for the MAC pipeline to drain, requests the bias add, then commands the result write. It sits between the layer-level start/done handshake and the feature buffer, kernel ROM, bias ROM and result RAM.

## Interface
Parameters:
- IN_NUMS, 1600, input elements per output neuron (DEPTH·H·W).
- OUT_NUMS, 128, number of output neurons (bias count).
- MAC_LAT, 1, cycles from a MAC issue until its product is accumulated; must be ≥ 1.
- FA_W, $clog2(IN_NUMS), feature address width.
- KA_W, $clog2(IN_NUMS*OUT_NUMS), kernel address width.
- OA_W, $clog2(OUT_NUMS), bias and result address width.

Ports:
- clk  in  1  single clock; all logic updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  starts a layer pass; sampled only in IDLE.
- stall_i  in  1  upstream not ready; freezes issue in RUN only.
- busy_o  out  1  high from the cycle after start is accepted through the DONE cycle.
- done_o  out  1  one-cycle pulse at pass end.
- mac_en_o  out  1  a MAC is issued this cycle.
- acc_first_o  out  1  qualifies mac_en_o; the issued product loads the accumulator instead of adding to it.
- feat_addr_o  out  FA_W  feature index for the issued MAC.
- kern_addr_o  out  KA_W  kernel index = out_idx·IN_NUMS + in_idx.
- bias_en_o  out  1  add bias[bias_addr_o] to the accumulator.
- bias_addr_o  out  OA_W  current out_idx.
- res_we_o  out  1  write the accumulator to result[res_addr_o].
- res_addr_o  out  OA_W  current out_idx.

## Operation
- Counters: in_idx (0..IN_NUMS-1), out_idx (0..OUT_NUMS-1), drain_cnt (0..MAC_LAT-1). kern_addr is kept by an incrementing register, not a multiplier.
- FSM states and transitions:
  - IDLE: go to RUN on start_i; clear all counters.
  - RUN: each cycle with !stall_i, assert mac_en_o and increment in_idx. acc_first_o is high iff in_idx==0. After issuing in_idx==IN_NUMS-1, go to DRAIN.
  - DRAIN: hold for MAC_LAT cycles, then go to BIAS.
  - BIAS: assert bias_en_o for 1 cycle, then go to WRITE.
  - WRITE: assert res_we_o for 1 cycle. If out_idx==OUT_NUMS-1, go to DONE. Otherwise increment out_idx, clear in_idx, and go to RUN.
  - DONE: assert done_o for 1 cycle, then go to IDLE.
- Address behaviour:
  - While in RUN, feat_addr_o and kern_addr_o are valid whenever mac_en_o is high. In other states they hold their last value and must not be interpreted.
  - kern_addr_o is continuous across outputs (0 .. IN_NUMS·OUT_NUMS-1). It returns to 0 only from IDLE.
- Stall:
  - With stall_i high in RUN: mac_en_o=0 and all counters hold. Issue resumes at the same in_idx.
  - stall_i is ignored in DRAIN, BIAS, WRITE and DONE.
- Start handling:
  - start_i is ignored outside IDLE, with no queuing.
  - start_i high in the DONE cycle is also ignored. A new pass needs start_i in IDLE.
- Reset:
  - Reset state is IDLE, all counters 0, all outputs 0 (including addresses).
  - rst asserted mid-pass aborts at the next edge, with no done_o and no further res_we_o.
- Edge cases:
  - IN_NUMS=1: RUN lasts exactly one issue cycle, and acc_first_o=1 on it.
  - OUT_NUMS=1: the first WRITE goes directly to DONE.

## Timing
- All outputs are registered and decoded from the current state and counters; there are no combinational paths from start_i.
- start_i sampled high at edge t gives the first mac_en_o in cycle t+1.
- Per output neuron, with no stall: IN_NUMS + MAC_LAT + 2 cycles. Each stalled RUN cycle adds 1.
- Full pass: OUT_NUMS·(IN_NUMS+MAC_LAT+2) cycles of busy_o before DONE. done_o is in the following cycle, and busy_o is also high during DONE.
- bias_en_o is at least MAC_LAT cycles after the last mac_en_o of a neuron.
- res_we_o is exactly 1 cycle after bias_en_o. The datapath's FloatingAddition must settle the bias sum within that cycle.

## Test plan
- IN_NUMS=4, OUT_NUMS=3, MAC_LAT=2, start pulse at cycle 0:
  - mac_en_o high in cycles 1–4, 9–12 and 17–20.
  - kern_addr_o runs 0–3, 4–7, 8–11, with acc_first_o in cycles 1, 9, 17.
  - bias_en_o in cycles 7, 15, 23; res_we_o in cycles 8, 16, 24 with res_addr_o 0, 1, 2.
  - done_o in cycle 25; busy_o high in cycles 1–25.
- Same configuration with stall_i high in cycles 2–3: mac_en_o in cycles 1, 4, 5, 6 with feat_addr_o 0, 1, 2, 3; every later event shifts by +2 and done_o is in cycle 27.
- start_i held high for the whole pass: exactly one pass runs, and a second pass begins only after returning to IDLE (first mac_en_o of pass two in cycle 27).
- rst at cycle 10 of the first scenario: from cycle 11 all outputs are 0 and the block stays in IDLE. A new start gives kern_addr_o=0 with acc_first_o=1.
- IN_NUMS=1, OUT_NUMS=1, MAC_LAT=1: mac_en_o and acc_first_o in cycle 1, bias_en_o in cycle 3, res_we_o in cycle 4, done_o in cycle 5.
- start_i asserted in cycles 5 and 25 (DONE) of the first scenario: both are ignored and no extra mac_en_o appears.
